// File: rtl/elevator_pkg.sv
// Shared state type, direction constants and sensor-decode helpers for elevator_ctrl_n.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    DOOR_OPEN
  } state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int unsigned MAX_FLOORS = 16;

  function automatic logic [3:0] onehot_to_idx(input logic [MAX_FLOORS-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_FLOORS; i++) begin
      if (oh[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [MAX_FLOORS-1:0] v);
    return (v != '0) && ((v & (v - 16'd1)) == '0);
  endfunction

endpackage

// File: rtl/elevator_door_timer.sv
// Door-open interval counter: load or hold pins it at the full interval, done_o marks expiry.
module elevator_door_timer #(
  parameter int unsigned DOOR_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic hold_i,
  output logic done_o
);

  localparam int unsigned CW = $clog2(DOOR_CYCLES);
  localparam logic [CW-1:0] LOAD_VAL = CW'(DOOR_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i || hold_i) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done_o = !load_i && !hold_i && (cnt_q == '0);

endmodule

// File: rtl/elevator_ctrl_n.sv
// N-floor SCAN elevator controller: request latches, scheduler and Moore output decode.
// Build option DOOR_HOLD_EN adds input door_hold, which keeps the door open while asserted.
module elevator_ctrl_n
  import elevator_pkg::*;
#(
  parameter  int unsigned FLOORS      = 4,
  parameter  int unsigned DOOR_CYCLES = 8,
  localparam int unsigned FLW         = $clog2(FLOORS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOORS-1:0] floor_sensor,
  input  logic [FLOORS-1:0] hall_up,
  input  logic [FLOORS-1:0] hall_dn,
  input  logic [FLOORS-1:0] car_req,
`ifdef DOOR_HOLD_EN
  input  logic              door_hold,
`endif
  output logic              up,
  output logic              down,
  output logic              stop,
  output logic              open_door,
  output logic [FLW-1:0]    cur_floor,
  output logic [FLOORS-1:0] pend_req
);

  state_e            state_q, state_d;
  logic              dir_q, dir_d;
  logic [FLW-1:0]    cur_floor_q, cur_floor_d;
  logic [FLOORS-1:0] req_up_q, req_up_d, req_dn_q, req_dn_d, req_car_q, req_car_d;
  logic [FLOORS-1:0] set_up, set_dn, set_car, all_req;
  logic [FLW-1:0]    sens_idx, stop_f;
  logic              sens_valid, absorb, hold_door, timer_load, door_done, enter_door;
  logic              serve_here, serve_sens, above_c, below_c;

  function automatic logic beyond(input logic [FLOORS-1:0] r, input logic [FLW-1:0] f,
                                  input logic d);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < FLOORS; i++) begin
      if (r[i] && ((d == DIR_UP) ? (i > 32'(f)) : (i < 32'(f)))) hit = 1'b1;
    end
    return hit;
  endfunction

  // Opposite-direction hall call is only served once nothing remains further along.
  function automatic logic serve_at(input logic [FLOORS-1:0] car, input logic [FLOORS-1:0] u,
                                    input logic [FLOORS-1:0] dn, input logic [FLW-1:0] f,
                                    input logic d);
    logic far;
    far = beyond(car | u | dn, f, d);
    if (d == DIR_UP) return car[f] | u[f] | (dn[f] & ~far);
    else             return car[f] | dn[f] | (u[f] & ~far);
  endfunction

  assign sens_valid = is_onehot(16'(floor_sensor));
  assign sens_idx   = FLW'(onehot_to_idx(16'(floor_sensor)));
  assign all_req    = req_up_q | req_dn_q | req_car_q;
  assign above_c    = beyond(all_req, cur_floor_q, DIR_UP);
  assign below_c    = beyond(all_req, cur_floor_q, DIR_DOWN);
  assign serve_here = serve_at(req_car_q, req_up_q, req_dn_q, cur_floor_q, dir_q);
  assign serve_sens = serve_at(req_car_q, req_up_q, req_dn_q, sens_idx, dir_q);
  assign cur_floor_d = sens_valid ? sens_idx : cur_floor_q;

  always_comb begin
    set_up  = hall_up;
    set_dn  = hall_dn;
    set_car = car_req;
    set_up[FLOORS-1] = 1'b0;
    set_dn[0]        = 1'b0;
    absorb = 1'b0;
    if (state_q == DOOR_OPEN) begin
      absorb = set_up[cur_floor_q] | set_dn[cur_floor_q] | set_car[cur_floor_q];
      set_up[cur_floor_q]  = 1'b0;
      set_dn[cur_floor_q]  = 1'b0;
      set_car[cur_floor_q] = 1'b0;
    end
  end

`ifdef DOOR_HOLD_EN
  assign hold_door = door_hold && (state_q == DOOR_OPEN);
`else
  assign hold_door = 1'b0;
`endif

  // Preloading while outside DOOR_OPEN avoids a load path through next-state logic.
  assign timer_load = (state_q != DOOR_OPEN) || absorb;

  elevator_door_timer #(.DOOR_CYCLES(DOOR_CYCLES)) u_door_timer (
    .clk    (clk),
    .reset  (reset),
    .load_i (timer_load),
    .hold_i (hold_door),
    .done_o (door_done)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    stop_f  = cur_floor_q;
    case (state_q)
      IDLE: begin
        if (serve_here) begin
          state_d = DOOR_OPEN;
        end else if (above_c && (dir_q == DIR_UP || !below_c)) begin
          state_d = MOVE_UP;
          dir_d   = DIR_UP;
        end else if (below_c) begin
          state_d = MOVE_DOWN;
          dir_d   = DIR_DOWN;
        end
      end
      MOVE_UP: begin
        stop_f = sens_idx;
        if (sens_valid && (serve_sens || sens_idx == FLW'(FLOORS - 1))) state_d = DOOR_OPEN;
      end
      MOVE_DOWN: begin
        stop_f = sens_idx;
        if (sens_valid && (serve_sens || sens_idx == '0)) state_d = DOOR_OPEN;
      end
      DOOR_OPEN: begin
        if (door_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign enter_door = (state_d == DOOR_OPEN) && (state_q != DOOR_OPEN);

  always_comb begin
    req_up_d  = req_up_q | set_up;
    req_dn_d  = req_dn_q | set_dn;
    req_car_d = req_car_q | set_car;
    if (enter_door) begin
      req_car_d[stop_f] = 1'b0;
      if (dir_d == DIR_UP) req_up_d[stop_f] = 1'b0;
      else                 req_dn_d[stop_f] = 1'b0;
      if (!beyond(all_req, stop_f, dir_d)) begin
        req_up_d[stop_f] = 1'b0;
        req_dn_d[stop_f] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      dir_q       <= DIR_UP;
      cur_floor_q <= '0;
      req_up_q    <= '0;
      req_dn_q    <= '0;
      req_car_q   <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      cur_floor_q <= cur_floor_d;
      req_up_q    <= req_up_d;
      req_dn_q    <= req_dn_d;
      req_car_q   <= req_car_d;
    end
  end

  assign up        = (state_q == MOVE_UP);
  assign down      = (state_q == MOVE_DOWN);
  assign stop      = (state_q == IDLE) || (state_q == DOOR_OPEN);
  assign open_door = (state_q == DOOR_OPEN);
  assign cur_floor = cur_floor_q;
  assign pend_req  = all_req;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Bench for elevator_ctrl_n: a floor-list model checked every cycle plus directed scenario checks.
module tb_elevator_ctrl_n;

  localparam int NF = 4;
  localparam int DC = 8;
  localparam int M_IDLE = 0, M_UP = 1, M_DOWN = 2, M_DOOR = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NF-1:0] floor_sensor = 4'b0001;
  logic [NF-1:0] hall_up = '0, hall_dn = '0, car_req = '0;
`ifdef DOOR_HOLD_EN
  logic          door_hold = 1'b0;
`endif
  logic          up, down, stop, open_door;
  logic [1:0]    cur_floor;
  logic [NF-1:0] pend_req;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;
  bit plant_en = 1'b1;
  int pos = 0;
  int sub = 0;

  elevator_ctrl_n #(.FLOORS(NF), .DOOR_CYCLES(DC)) dut (
    .clk          (clk),
    .reset        (reset),
    .floor_sensor (floor_sensor),
    .hall_up      (hall_up),
    .hall_dn      (hall_dn),
    .car_req      (car_req),
`ifdef DOOR_HOLD_EN
    .door_hold    (door_hold),
`endif
    .up           (up),
    .down         (down),
    .stop         (stop),
    .open_door    (open_door),
    .cur_floor    (cur_floor),
    .pend_req     (pend_req)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- behavioural model: per-floor request lists, travel sign +1/-1
  bit m_up[NF], m_dn[NF], m_car[NF];
  int m_mode = M_IDLE, m_dir = 1, m_cur = 0, m_timer = 0;

  function automatic bit any_req(int i);
    return m_up[i] | m_dn[i] | m_car[i];
  endfunction

  function automatic bit req_beyond(int f, int d);
    for (int i = 0; i < NF; i++) if ((i - f) * d > 0 && any_req(i)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit stops_at(int f, int d);
    bit with_d, against;
    with_d  = (d > 0) ? m_up[f] : m_dn[f];
    against = (d > 0) ? m_dn[f] : m_up[f];
    return m_car[f] | with_d | (against & !req_beyond(f, d));
  endfunction

  task automatic model_step();
    int cnt, sidx, f, nmode, hold;
    bit sval, enter, far, hit;
    cnt = 0; sidx = 0;
    for (int i = 0; i < NF; i++) if (floor_sensor[i]) begin cnt++; sidx = i; end
    sval = (cnt == 1);
    if (reset) begin
      for (int i = 0; i < NF; i++) begin m_up[i] = 0; m_dn[i] = 0; m_car[i] = 0; end
      m_mode = M_IDLE; m_dir = 1; m_cur = 0; m_timer = 0;
      return;
    end
    hold = 0;
`ifdef DOOR_HOLD_EN
    hold = door_hold;
`endif
    nmode = m_mode; f = m_cur;
    hit = car_req[m_cur] | (hall_up[m_cur] && m_cur < NF-1) | (hall_dn[m_cur] && m_cur > 0);
    if (m_mode == M_IDLE) begin
      if (stops_at(m_cur, m_dir)) nmode = M_DOOR;
      else if (req_beyond(m_cur, 1) && (m_dir > 0 || !req_beyond(m_cur, -1))) begin
        nmode = M_UP; m_dir = 1;
      end else if (req_beyond(m_cur, -1)) begin
        nmode = M_DOWN; m_dir = -1;
      end
    end else if (m_mode == M_UP || m_mode == M_DOWN) begin
      if (sval) begin
        f = sidx;
        if (stops_at(f, m_dir) || f == (m_dir > 0 ? NF-1 : 0)) nmode = M_DOOR;
      end
    end else begin
      if (hit || hold) m_timer = DC - 1;
      else if (m_timer == 0) nmode = M_IDLE;
      else m_timer--;
    end
    enter = (nmode == M_DOOR) && (m_mode != M_DOOR);
    far = req_beyond(f, m_dir);
    for (int i = 0; i < NF; i++) begin
      if (!(m_mode == M_DOOR && i == m_cur)) begin
        if (car_req[i]) m_car[i] = 1;
        if (hall_up[i] && i < NF-1) m_up[i] = 1;
        if (hall_dn[i] && i > 0) m_dn[i] = 1;
      end
    end
    if (enter) begin
      m_car[f] = 0;
      if (m_dir > 0) m_up[f] = 0; else m_dn[f] = 0;
      if (!far) begin m_up[f] = 0; m_dn[f] = 0; end
      m_timer = DC - 1;
    end
    if (sval) m_cur = sidx;
    m_mode = nmode;
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    logic [NF-1:0] mp;
    if (cmp_en) begin
      for (int i = 0; i < NF; i++) mp[i] = any_req(i);
      check("model_up", up, m_mode == M_UP);
      check("model_down", down, m_mode == M_DOWN);
      check("model_stop", stop, m_mode == M_IDLE || m_mode == M_DOOR);
      check("model_open_door", open_door, m_mode == M_DOOR);
      check("model_cur_floor", cur_floor, m_cur);
      check("model_pend_req", pend_req, mp);
    end
  end

  // ---------------- stimulus: car plant moves one floor every 3 cycles of motor drive
  task automatic tick();
    @(posedge clk);
    #1;
    if (plant_en) begin
      if (up || down) begin
        sub++;
        if (sub >= 3) begin
          sub = 0;
          pos = up ? pos + 1 : pos - 1;
          if (pos < 0) pos = 0;
          if (pos > NF-1) pos = NF-1;
          floor_sensor = 4'b0001 << pos;
        end else begin
          floor_sensor = '0;
        end
      end else begin
        sub = 0;
        floor_sensor = 4'b0001 << pos;
      end
    end
  endtask

  task automatic serve(output int floor, output int ncyc);
    int w;
    w = 0;
    while (!open_door && w < 200) begin tick(); w++; end
    check("door_open_timeout", open_door, 1);
    floor = cur_floor;
    ncyc = 0;
    while (open_door && ncyc < 100) begin tick(); ncyc++; end
  endtask

  initial begin
    int f, n, w;
    bit held;
    tick();
    tick();
    cmp_en = 1'b1;
    check("rst_stop", stop, 1);
    check("rst_open_door", open_door, 0);
    check("rst_up", up, 0);
    check("rst_down", down, 0);
    check("rst_cur_floor", cur_floor, 0);
    check("rst_pend_req", pend_req, 4'b0000);
    reset = 1'b0;
    tick();

    // floor 0 -> car call to 3
    car_req = 4'b1000; tick(); car_req = '0;
    check("latch_pend", pend_req, 4'b1000);
    check("latch_still_idle", up, 0);
    tick();
    check("move_up_next", up, 1);
    check("move_up_stop_low", stop, 0);
    serve(f, n);
    check("t2_stop_floor", f, 3);
    check("t2_door_cycles", n, 8);
    check("t2_pend_clear", pend_req, 4'b0000);
    check("t2_idle_stop", stop, 1);

    car_req = 4'b0001; tick(); car_req = '0;
    serve(f, n);
    check("back_to_0", f, 0);

    // hall down at 2 passed on the way up, served after reversal
    hall_dn = 4'b0100; car_req = 4'b1000; tick(); hall_dn = '0; car_req = '0;
    serve(f, n);
    check("scan_first_stop", f, 3);
    serve(f, n);
    check("scan_second_stop", f, 2);
    check("scan_pend_clear", pend_req, 4'b0000);

    // idle at 1 heading up with calls at 0 and 3
    car_req = 4'b0001; tick(); car_req = '0;
    serve(f, n);
    check("t4_pre0", f, 0);
    car_req = 4'b0010; tick(); car_req = '0;
    serve(f, n);
    check("t4_pre1", f, 1);
    car_req = 4'b1001; tick(); car_req = '0;
    tick();
    check("t4_goes_up_first", up, 1);
    serve(f, n);
    check("t4_first_3", f, 3);
    serve(f, n);
    check("t4_then_0", f, 0);

    // request at the open floor reloads the door timer
    car_req = 4'b0100; tick(); car_req = '0;
    w = 0;
    while (!open_door && w < 200) begin tick(); w++; end
    check("t5_open", open_door, 1);
    check("t5_floor", cur_floor, 2);
    n = 0;
    while (open_door && n < 100) begin
      if (n == 6) car_req[2] = 1'b1;
      tick();
      car_req = '0;
      n++;
    end
    check("t5_reload_cycles", n, 15);
    check("t5_not_latched", pend_req, 4'b0000);

    // ignored hall bits at the ends
    hall_up = 4'b1000; hall_dn = 4'b0001; tick(); hall_up = '0; hall_dn = '0;
    tick();
    check("ignored_bits_pend", pend_req, 4'b0000);
    check("ignored_bits_no_move", up | down, 0);

    // zero / multi-bit sensor holds the floor
    plant_en = 1'b0;
    floor_sensor = 4'b0011; tick(); tick();
    check("multi_sensor_hold", cur_floor, 2);
    floor_sensor = 4'b0000; tick();
    check("zero_sensor_hold", cur_floor, 2);
    plant_en = 1'b1;
    tick();

`ifdef DOOR_HOLD_EN
    car_req = 4'b0100; tick(); car_req = '0;
    w = 0;
    while (!open_door && w < 50) begin tick(); w++; end
    check("hold_open", open_door, 1);
    door_hold = 1'b1;
    held = 1'b1;
    repeat (20) begin tick(); if (!open_door) held = 1'b0; end
    check("hold_keeps_open", held, 1);
    door_hold = 1'b0;
    n = 0;
    while (open_door && n < 100) begin tick(); n++; end
    check("hold_release_cycles", n, DC);
`endif

    // reset while moving down
    car_req = 4'b0001; hall_up = 4'b0010; tick(); car_req = '0; hall_up = '0;
    check("t6_pend", pend_req, 4'b0011);
    w = 0;
    while (!down && w < 20) begin tick(); w++; end
    check("t6_moving_down", down, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("t6_rst_stop", stop, 1);
    check("t6_rst_down", down, 0);
    check("t6_rst_pend", pend_req, 4'b0000);
    check("t6_rst_cur", cur_floor, 0);
    tick();
    check("t6_reacquire", cur_floor, 2);
    tick();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
